// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace sequencer: FSM states, beat kind codes
// and the record counter width.
package cpu_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT_PC,
    ST_EMIT_INSTR,
    ST_EMIT_REG,
    ST_FINISHED
  } trace_state_t;

  localparam logic [1:0] KIND_PC    = 2'd0;
  localparam logic [1:0] KIND_INSTR = 2'd1;
  localparam logic [1:0] KIND_REG   = 2'd2;

  localparam int RECORD_CNT_W = 16;

endpackage

// File: rtl/regfile_trace_ctrl.sv
// Trace sequencer: after each retired instruction, stalls the core and streams
// PC, instruction word and all register-file entries over a valid/ready port.
import cpu_trace_pkg::*;

module regfile_trace_ctrl #(
  parameter int NUM_REGS    = 32,
  parameter int REG_AW      = 5,
  parameter int DATA_W      = 32,
  parameter int MAX_RECORDS = 153
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    retire_valid,
  input  logic [DATA_W-1:0]       retire_pc,
  input  logic [DATA_W-1:0]       retire_instr,
  output logic                    cpu_stall,
  output logic [REG_AW-1:0]       rf_raddr,
  input  logic [DATA_W-1:0]       rf_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_kind,
  output logic [REG_AW-1:0]       out_index,
  output logic [DATA_W-1:0]       out_data,
  output logic [RECORD_CNT_W-1:0] record_count,
  output logic                    done,
  output logic                    overrun
);

  trace_state_t            state, state_nxt;
  logic [REG_AW-1:0]       reg_idx, reg_idx_nxt;
  logic [DATA_W-1:0]       held_pc, held_instr;
  logic                    latch_retire;
  logic                    record_done;
  logic                    handshake;
  logic                    last_reg;
  logic [RECORD_CNT_W-1:0] count_inc;

  assign handshake = out_valid && out_ready;
  assign last_reg  = (reg_idx == REG_AW'(NUM_REGS - 1));
  assign count_inc = record_count + RECORD_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      reg_idx      <= '0;
      held_pc      <= '0;
      held_instr   <= '0;
      record_count <= '0;
      overrun      <= 1'b0;
    end else begin
      state   <= state_nxt;
      reg_idx <= reg_idx_nxt;
      if (latch_retire) begin
        held_pc    <= retire_pc;
        held_instr <= retire_instr;
      end
      if (record_done) record_count <= count_inc;
      // A retire while the core is supposedly frozen means the stall was ignored.
      if (retire_valid && cpu_stall) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    reg_idx_nxt  = reg_idx;
    latch_retire = 1'b0;
    record_done  = 1'b0;
    cpu_stall    = 1'b0;
    out_valid    = 1'b0;
    out_kind     = KIND_PC;
    out_index    = '0;
    out_data     = '0;
    rf_raddr     = '0;
    done         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (enable && retire_valid) begin
          latch_retire = 1'b1;
          state_nxt    = ST_EMIT_PC;
        end
      end
      ST_EMIT_PC: begin
        cpu_stall = 1'b1;
        out_valid = 1'b1;
        out_kind  = KIND_PC;
        out_data  = held_pc;
        if (handshake) state_nxt = ST_EMIT_INSTR;
      end
      ST_EMIT_INSTR: begin
        cpu_stall = 1'b1;
        out_valid = 1'b1;
        out_kind  = KIND_INSTR;
        out_data  = held_instr;
        if (handshake) begin
          state_nxt   = ST_EMIT_REG;
          reg_idx_nxt = '0;
        end
      end
      ST_EMIT_REG: begin
        cpu_stall = 1'b1;
        out_valid = 1'b1;
        out_kind  = KIND_REG;
        out_index = reg_idx;
        rf_raddr  = reg_idx;
        out_data  = rf_rdata;
        if (handshake) begin
          if (last_reg) begin
            record_done = 1'b1;
            reg_idx_nxt = '0;
            state_nxt   = (count_inc == RECORD_CNT_W'(MAX_RECORDS)) ? ST_FINISHED : ST_IDLE;
          end else begin
            reg_idx_nxt = reg_idx + REG_AW'(1);
          end
        end
      end
      ST_FINISHED: begin
        done = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
